sys_array_stream_fetcher: RTL
=============================

# sys_array_stream_fetcher

Parametrised successor to the fixed-size systolic fetcher. It accepts operand matrices A (ARRAY_W x L) and B (L x ARRAY_H) over a valid/ready stream, with the inner dimension L chosen at run time up to MAX_L. It buffers the operands and feeds them, skewed, into an output-stationary ARRAY_W x ARRAY_H PE grid, then presents the full product C = A·B. It sits between the operand DMA/host interface and result readout, and can recompute on buffered operands without reloading them.

## Interface
- DATA_WIDTH, 8: operand element width.
- ARRAY_W, 4: PE rows; rows of A and C.
- ARRAY_H, 4: PE columns; columns of B and C.
- MAX_L, 16: maximum inner dimension and operand buffer depth.
- ACC_WIDTH, 2*DATA_WIDTH+$clog2(MAX_L): accumulator and result element width (derived; not overridden).
- clk  in  1  sole clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- load_params  in  1  single-cycle pulse; captures len_l and starts an operand load.
- len_l  in  $clog2(MAX_L+1)  inner dimension L; legal range is 1..MAX_L.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat.
- in_a  in  ARRAY_W x DATA_WIDTH  column k of A; element [i] is A[i][k].
- in_b  in  ARRAY_H x DATA_WIDTH  row k of B; element [j] is B[k][j].
- start_comp  in  1  start a computation; sampled every cycle.
- busy  out  1  high during computation.
- ready  out  1  out_data is valid; held.
- err_param  out  1  last load_params carried an illegal len_l.
- out_data  out  [0:ARRAY_W-1][0:ARRAY_H-1] x ACC_WIDTH  result matrix C.

## Operation
- FSM states: IDLE, LOAD, LOADED, COMP, DONE. The block enters IDLE on reset.
- IDLE / LOADED / DONE on load_params:
  - Legal len_l: latch len_l, clear wr_ptr and err_param, go to LOAD.
  - len_l = 0 or len_l > MAX_L: set err_param, go to IDLE. Buffered operands are invalidated.
- LOAD:
  - in_ready=1.
  - Each beat with in_valid&in_ready writes buffer[wr_ptr] and increments wr_ptr.
  - The beat that makes wr_ptr equal L moves the FSM to LOADED. in_ready drops in the next cycle, so no extra beat is accepted.
- LOADED or DONE on start_comp=1: go to COMP, clear all accumulators, clear the step counter t, and clear ready.
- COMP, at step t:
  - Row-i feed = A[i][t-i]; column-j feed = B[t-j][j]. Any out-of-range index (outside 0..L-1) gives 0.
  - The PE passes a to the right and b downward through registers. PE(i,j) therefore sees operand index k = t-i-j and does acc += a*b.
  - COMP lasts exactly L+ARRAY_W+ARRAY_H-2 cycles, then the FSM goes to DONE.
- DONE:
  - ready=1.
  - out_data = accumulators, held until the next COMP entry.
  - The buffer is retained, so start_comp recomputes on it.
- Ignored inputs:
  - start_comp in IDLE or LOAD.
  - load_params and start_comp during COMP.
  - in_valid outside LOAD.
- Simultaneous load_params and start_comp in LOADED or DONE: load_params wins.
- Arithmetic: full-precision products, accumulated in ACC_WIDTH. No overflow is possible for L <= MAX_L.

## Timing
- Reset value of every output: in_ready=0, busy=0, ready=0, err_param=0, out_data=0. Reset clears the FSM, wr_ptr, t, and accumulators immediately (asynchronous). Buffer contents become don't-care and require a reload.
- in_ready rises in the cycle after the load_params edge.
- start_comp sampled at edge n:
  - busy is high for cycles n+1 .. n+L+W+H-2.
  - ready rises at edge n+L+W+H-1, i.e. L+ARRAY_W+ARRAY_H-1 cycles after start.
- err_param is updated in the cycle after load_params and stays sticky until the next load_params.

## Configuration
- SYS_ARRAY_SIGNED_EN defined: operands and accumulators are two's-complement signed; products are sign-extended to ACC_WIDTH.
- SYS_ARRAY_SIGNED_EN undefined: everything is unsigned and zero-extended.
- The macro affects only the PE multiply/accumulate; the interface is identical in both builds.

## Structure
- Package sys_array_pkg: FSM state enum, ACC_WIDTH/len-width helper functions, step-count constant expression.
- Sub-module sys_array_pe: one MAC cell with registered a/b pass-through, accumulator clear, and enable. It is instantiated ARRAY_W x ARRAY_H times in a generate block.
- The operand buffer and skew feed logic live in the top module.

## Test plan
- Identity: defaults, len_l=4, A=I4, B[k][j]=4k+j+1. Required: out_data[i][j]=4i+j+1, and ready exactly 11 cycles after start_comp.
- Minimum depth: len_l=1, all a=3, all b=5. Required: every out_data element =15; ready 8 cycles after start; busy high 7 cycles.
- Full-scale: len_l=16.
  - Unsigned build, all elements 255: every element =1040400.
  - SYS_ARRAY_SIGNED_EN build, all elements -128: every element =262144.
- Bad parameters: load_params with len_l=0, then with len_l=17. Required: err_param=1, in_ready=0, and start_comp ignored (busy stays 0). Then len_l=2: err_param=0 and in_ready=1.
- Stream corners:
  - Random in_valid gaps: result unaffected.
  - A 5th beat offered with len_l=4: not accepted.
  - start_comp during LOAD: ignored.
  - Second start_comp in DONE: identical result, and ready low for the full recompute.
- Reset mid-COMP: reset_n low at step 3. Required: all outputs 0 immediately. After release, start_comp is ignored until a new load completes.

Source files
------------

// File: rtl/sys_array_pkg.sv
// -----------------------------------------------------------------------------
// sys_array_pkg
//   Shared definitions for the systolic-array stream fetcher:
//     - state_t     : control FSM states
//     - acc_width() : accumulator / result element width for a given operand
//                     width and maximum inner dimension
//     - len_width() : width of the run-time inner-dimension field
//     - step_width(): width of the compute step counter
//     - comp_steps(): number of compute cycles for a given L and grid size
// -----------------------------------------------------------------------------
package sys_array_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    LOADED = 3'd2,
    COMP   = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Full-precision product plus enough headroom for MAX_L accumulations.
  function automatic int acc_width(input int data_width, input int max_l);
    return 2 * data_width + $clog2(max_l);
  endfunction

  // len_l must be able to hold MAX_L itself (and illegal MAX_L+1).
  function automatic int len_width(input int max_l);
    return $clog2(max_l + 1);
  endfunction

  // The last operand reaches the far corner PE at step L+W+H-3; one extra
  // code point lets the counter step past it harmlessly.
  function automatic int comp_steps(input int len, input int w, input int h);
    return len + w + h - 2;
  endfunction

  function automatic int step_width(input int max_l, input int w, input int h);
    return $clog2(comp_steps(max_l, w, h) + 1);
  endfunction

endpackage

// File: rtl/sys_array_pe.sv
// -----------------------------------------------------------------------------
// sys_array_pe
//   One output-stationary MAC cell of the systolic grid.
//   Ports:
//     clk, reset_n : clock, asynchronous active-low reset
//     clr          : synchronous clear of accumulator and pass-through regs
//     en           : advance one step (register a/b, accumulate a*b)
//     a_in, b_in   : operands from the left / from above
//     a_out, b_out : registered operands to the right / downward
//     acc          : running sum of products
//   Build option: SYS_ARRAY_SIGNED_EN selects two's-complement operands and
//   sign-extended products; otherwise everything is unsigned.
// -----------------------------------------------------------------------------
module sys_array_pe #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 20
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clr,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  output logic [DATA_WIDTH-1:0] a_out,
  output logic [DATA_WIDTH-1:0] b_out,
  output logic [ACC_WIDTH-1:0]  acc
);

`ifdef SYS_ARRAY_SIGNED_EN
  localparam logic SIGNED_MAC = 1'b1;
`else
  localparam logic SIGNED_MAC = 1'b0;
`endif

  localparam int PW = 2 * DATA_WIDTH;

  logic [PW-1:0]        a_ext;
  logic [PW-1:0]        b_ext;
  logic [PW-1:0]        prod;
  logic [ACC_WIDTH-1:0] prod_ext;

  // Operands are widened to the product width before multiplying, so the low
  // PW bits of the product are exact in both signed and unsigned builds and
  // the accumulator can use plain modular addition.
  always_comb begin
    a_ext    = {{DATA_WIDTH{SIGNED_MAC & a_in[DATA_WIDTH-1]}}, a_in};
    b_ext    = {{DATA_WIDTH{SIGNED_MAC & b_in[DATA_WIDTH-1]}}, b_in};
    prod     = a_ext * b_ext;
    prod_ext = {{(ACC_WIDTH-PW){SIGNED_MAC & prod[PW-1]}}, prod};
  end

  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values of its neighbours, which is what makes the systolic
  // shift work regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else if (clr) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else if (en) begin
      a_out <= a_in;
      b_out <= b_in;
      acc   <= acc + prod_ext;
    end
  end

endmodule

// File: rtl/sys_array_stream_fetcher.sv
// -----------------------------------------------------------------------------
// sys_array_stream_fetcher
//   Buffers operand matrices A (ARRAY_W x L) and B (L x ARRAY_H) received over
//   a valid/ready stream, feeds them skewed into an ARRAY_W x ARRAY_H grid of
//   sys_array_pe cells and presents C = A*B. Buffered operands are retained so
//   start_comp can recompute without a reload.
//   Ports:
//     clk, reset_n  : clock, asynchronous active-low reset
//     load_params   : pulse; captures len_l and starts an operand load
//     len_l         : inner dimension L (legal 1..MAX_L)
//     in_valid      : operand beat valid
//     in_ready      : beat accepted (high in LOAD)
//     in_a          : column k of A, element i at [i*DATA_WIDTH +: DATA_WIDTH]
//     in_b          : row k of B, element j at [j*DATA_WIDTH +: DATA_WIDTH]
//     start_comp    : start a computation on the buffered operands
//     busy          : computation in progress
//     ready         : out_data holds a valid result
//     err_param     : last load_params carried an illegal len_l (sticky)
//     out_data      : C, element (i,j) at [(i*ARRAY_H+j)*ACC_WIDTH +: ACC_WIDTH]
//   Build option: SYS_ARRAY_SIGNED_EN (see sys_array_pe) selects signed MAC.
// -----------------------------------------------------------------------------
module sys_array_stream_fetcher
  import sys_array_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int ARRAY_W    = 4,
  parameter  int ARRAY_H    = 4,
  parameter  int MAX_L      = 16,
  localparam int ACC_WIDTH  = acc_width(DATA_WIDTH, MAX_L),
  localparam int LEN_W      = len_width(MAX_L)
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  load_params,
  input  logic [LEN_W-1:0]                      len_l,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [ARRAY_W*DATA_WIDTH-1:0]         in_a,
  input  logic [ARRAY_H*DATA_WIDTH-1:0]         in_b,
  input  logic                                  start_comp,
  output logic                                  busy,
  output logic                                  ready,
  output logic                                  err_param,
  output logic [ARRAY_W*ARRAY_H*ACC_WIDTH-1:0]  out_data
);

  localparam int ADDR_W = (MAX_L > 1) ? $clog2(MAX_L) : 1;
  localparam int STEP_W = step_width(MAX_L, ARRAY_W, ARRAY_H);
  localparam int A_BITS = ARRAY_W * DATA_WIDTH;
  localparam int B_BITS = ARRAY_H * DATA_WIDTH;

  state_t state, next_state;

  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  wr_ptr;
  logic [STEP_W-1:0] t;

  logic [A_BITS-1:0] buf_a [MAX_L];
  logic [B_BITS-1:0] buf_b [MAX_L];

  logic len_ok;
  logic accept_params;
  logic start_go;
  logic beat;
  logic last_beat;
  logic last_step;
  logic pe_en;

  // ---------------------------------------------------------------------------
  // Control FSM: next state and decoded controls
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    next_state    = state;
    in_ready      = 1'b0;
    pe_en         = 1'b0;
    len_ok        = (len_l != '0) && (int'(len_l) <= MAX_L);
    accept_params = 1'b0;
    start_go      = 1'b0;
    beat          = 1'b0;
    last_beat     = 1'b0;
    last_step     = (int'(t) == comp_steps(int'(len_q), ARRAY_W, ARRAY_H) - 1);

    unique case (state)
      IDLE, LOADED, DONE: begin
        accept_params = load_params;
        // load_params takes priority over a simultaneous start_comp; IDLE has
        // no valid operands, so start_comp is ignored there.
        start_go      = start_comp && !load_params && (state != IDLE);
        if (accept_params) begin
          next_state = len_ok ? LOAD : IDLE;
        end else if (start_go) begin
          next_state = COMP;
        end
      end
      LOAD: begin
        in_ready  = 1'b1;
        beat      = in_valid;
        last_beat = beat && ((wr_ptr + 1'b1) == len_q);
        if (last_beat) begin
          next_state = LOADED;
        end
      end
      COMP: begin
        pe_en = 1'b1;
        if (last_step) begin
          next_state = DONE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // Parameters, pointers, step counter and status outputs
  // ---------------------------------------------------------------------------
  // busy and ready are registered decodes, so they trail the FSM by one cycle:
  // busy covers the L+W+H-2 compute cycles shifted by one, and ready rises one
  // edge after the final accumulate. ready also drops on the very edge that
  // leaves DONE, so it never overlaps the accumulator clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len_q     <= '0;
      wr_ptr    <= '0;
      t         <= '0;
      err_param <= 1'b0;
      busy      <= 1'b0;
      ready     <= 1'b0;
    end else begin
      if (accept_params) begin
        err_param <= !len_ok;
        if (len_ok) begin
          len_q  <= len_l;
          wr_ptr <= '0;
        end
      end else if (beat) begin
        wr_ptr <= wr_ptr + 1'b1;
      end

      if (start_go) begin
        t <= '0;
      end else if (state == COMP) begin
        t <= t + 1'b1;
      end

      busy  <= (state == COMP);
      ready <= (state == DONE) && (next_state == DONE);
    end
  end

  // NOTE: the operand buffer has no reset; its contents are only read after a
  // complete load, and leaving it reset-free lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (beat) begin
      buf_a[wr_ptr[ADDR_W-1:0]] <= in_a;
      buf_b[wr_ptr[ADDR_W-1:0]] <= in_b;
    end
  end

  // ---------------------------------------------------------------------------
  // Skewed feed: row i is delayed by i steps, column j by j steps, so that
  // PE(i,j) sees operand index k = t-i-j once the pass-through registers have
  // carried the values across.
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] a_feed [ARRAY_W];
  logic [DATA_WIDTH-1:0] b_feed [ARRAY_H];

  always_comb begin
    for (int i = 0; i < ARRAY_W; i++) begin
      a_feed[i] = '0;
      if ((int'(t) >= i) && ((int'(t) - i) < int'(len_q))) begin
        a_feed[i] = buf_a[ADDR_W'(int'(t) - i)][i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    for (int j = 0; j < ARRAY_H; j++) begin
      b_feed[j] = '0;
      if ((int'(t) >= j) && ((int'(t) - j) < int'(len_q))) begin
        b_feed[j] = buf_b[ADDR_W'(int'(t) - j)][j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // PE grid
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] a_pass [ARRAY_W][ARRAY_H];
  logic [DATA_WIDTH-1:0] b_pass [ARRAY_W][ARRAY_H];

  for (genvar gi = 0; gi < ARRAY_W; gi++) begin : g_row
    for (genvar gj = 0; gj < ARRAY_H; gj++) begin : g_col
      logic [DATA_WIDTH-1:0] a_in_w;
      logic [DATA_WIDTH-1:0] b_in_w;

      if (gj == 0) begin : g_a_edge
        assign a_in_w = a_feed[gi];
      end else begin : g_a_inner
        assign a_in_w = a_pass[gi][gj-1];
      end

      if (gi == 0) begin : g_b_edge
        assign b_in_w = b_feed[gj];
      end else begin : g_b_inner
        assign b_in_w = b_pass[gi-1][gj];
      end

      sys_array_pe #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
      ) u_pe (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (start_go),
        .en      (pe_en),
        .a_in    (a_in_w),
        .b_in    (b_in_w),
        .a_out   (a_pass[gi][gj]),
        .b_out   (b_pass[gi][gj]),
        .acc     (out_data[(gi*ARRAY_H+gj)*ACC_WIDTH +: ACC_WIDTH])
      );
    end
  end

endmodule
